// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage pipeline: issues data-memory loads/stores over a
// req/ack handshake, stalls upstream while waiting, and registers the MEM/WB bundle.
module mem_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wmemi,
  input  logic        rmemi,
  input  logic        wregi,
  input  logic        wpci,
  input  logic [1:0]  jmpi,
  input  logic [2:0]  ALUInsi,
  input  logic [31:0] R2ri,
  input  logic [31:0] R3ri,
  input  logic [3:0]  DestRi,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wrego,
  output logic        wpco,
  output logic [1:0]  jmpo,
  output logic [2:0]  ALUInso,
  output logic [31:0] R2ro,
  output logic [31:0] R3ro,
  output logic [31:0] rdatao,
  output logic [3:0]  DestRo,
  output logic        fault
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       access, misaligned;
  logic       start, done, timed_out, stall_raw;
  logic       load_ack, fault_next;

  assign access     = wmemi | rmemi;
  assign misaligned = access & (R2ri[1:0] != 2'b00);

  always_comb begin
    state_next = state;
    count_next = count;
    stall_raw  = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !misaligned) begin
          stall_raw  = 1'b1;
          start      = 1'b1;
          count_next = 8'd0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_raw = !mem_ack && (count != LAST_CNT);
        if (mem_ack) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (count == LAST_CNT) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          state_next = S_IDLE;
        end else begin
          count_next = count + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stall must read 0 for the whole time reset is held, even mid-access.
  assign stall      = stall_raw & rst;
  assign load_ack   = (state == S_WAIT) & mem_ack & !mem_we;
  assign fault_next = misaligned | timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      count     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= wmemi;
        mem_addr  <= R2ri;
        mem_wdata <= R3ri;
      end else if (done) begin
        mem_req <= 1'b0;
      end
    end
  end

  // MEM/WB register: bubble while stalled, otherwise the (possibly faulted) bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrego   <= 1'b0;
      wpco    <= 1'b0;
      jmpo    <= 2'd0;
      ALUInso <= 3'd0;
      R2ro    <= 32'd0;
      R3ro    <= 32'd0;
      rdatao  <= 32'd0;
      DestRo  <= 4'd0;
      fault   <= 1'b0;
    end else if (stall_raw) begin
      wrego   <= 1'b0;
      wpco    <= 1'b0;
      jmpo    <= 2'd0;
      ALUInso <= 3'd0;
      R2ro    <= 32'd0;
      R3ro    <= 32'd0;
      rdatao  <= 32'd0;
      DestRo  <= 4'd0;
      fault   <= 1'b0;
    end else begin
      wrego   <= wregi & !fault_next;
      wpco    <= wpci & !fault_next;
      jmpo    <= fault_next ? 2'd0 : jmpi;
      ALUInso <= ALUInsi;
      R2ro    <= R2ri;
      R3ro    <= R3ri;
      rdatao  <= load_ack ? mem_rdata : 32'd0;
      DestRo  <= DestRi;
      fault   <= fault_next;
    end
  end

endmodule
